// File: rtl/uart_rx_pkt_ctrl_if.sv
// Byte stream bundle around the packet controller: receiver bytes in,
// payload bytes out.
//
// Handshake: the receiver side is a strobe (rx_valid may stay high for
// several cycles; only its rising edge carries a byte). The payload side is
// strict valid/ready: a byte transfers on every cycle where out_valid and
// out_ready are both high; once out_valid is up, out_data/out_last hold
// stable until that transfer, and out_valid never drops without one.
`timescale 1ns/1ps
interface uart_rx_pkt_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       out_ready;

  // Packet controller side
  modport master (
    input  rx_data,
    input  rx_valid,
    input  out_ready,
    output out_data,
    output out_valid,
    output out_last
  );

  // Receiver / consumer side
  modport slave (
    output rx_data,
    output rx_valid,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  out_last
  );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer for the UART receive path. Frames are
// SYNC, LEN, LEN payload bytes, CHK where CHK = (LEN + sum(payload)) mod 256.
// One payload is buffered, verified and then streamed out over valid/ready.
`timescale 1ns/1ps
module uart_rx_pkt_ctrl #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 52070
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_rx_pkt_ctrl_if.master         bus,
  output logic [15:0]                pkt_count,
  output logic                       err_chk,
  output logic                       err_len,
  output logic                       err_timeout,
  output logic                       err_ovf,
  output logic [2:0]                 state_dbg
);

  localparam int              IW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int              TW        = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0]   TIMEOUT_T = TW'(TIMEOUT);

  // Debug encoding is stable: IDLE=0, LEN=1, PAYLOAD=2, CHK=3, DRAIN=4
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rx_valid_q;
  logic [7:0]    len_q, len_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    wr_idx_q, wr_idx_d;
  logic [7:0]    rd_idx_q, rd_idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   pkt_count_q, pkt_count_d;
  logic          err_chk_q, err_chk_d;
  logic          err_len_q, err_len_d;
  logic          err_timeout_q, err_timeout_d;
  logic          err_ovf_q, err_ovf_d;

  logic          byte_ev;
  logic          mem_we;
  logic          drain_last;
  logic [7:0]    mem_q [MAX_LEN];

  // A held strobe yields a single byte: only its rising edge counts
  assign byte_ev    = bus.rx_valid & ~rx_valid_q;
  assign drain_last = (rd_idx_q == len_q - 8'd1);

  // Next-state, datapath updates and error pulse requests
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    chk_d         = chk_q;
    wr_idx_d      = wr_idx_q;
    rd_idx_d      = rd_idx_q;
    tmo_d         = '0;
    pkt_count_d   = pkt_count_q;
    err_chk_d     = 1'b0;
    err_len_d     = 1'b0;
    err_timeout_d = 1'b0;
    err_ovf_d     = 1'b0;
    mem_we        = 1'b0;

    // Inter-byte watchdog runs only while a frame is being collected;
    // an arriving byte always beats an expiring counter.
    if (state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CHK) begin
      if (byte_ev) begin
        tmo_d = '0;
      end else if (tmo_q == TIMEOUT_T) begin
        tmo_d         = '0;
        err_timeout_d = 1'b1;
        state_d       = S_IDLE;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (byte_ev && bus.rx_data == SYNC_BYTE) begin
          state_d = S_LEN;
        end
      end
      S_LEN: begin
        if (byte_ev) begin
          if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            len_d    = bus.rx_data;
            chk_d    = bus.rx_data;
            wr_idx_d = 8'd0;
            state_d  = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (byte_ev) begin
          mem_we   = 1'b1;
          chk_d    = chk_q + bus.rx_data;
          wr_idx_d = wr_idx_q + 8'd1;
          if (wr_idx_q == len_q - 8'd1) begin
            state_d = S_CHK;
          end
        end
      end
      S_CHK: begin
        if (byte_ev) begin
          if (bus.rx_data == chk_q) begin
            pkt_count_d = pkt_count_q + 16'd1;
            rd_idx_d    = 8'd0;
            state_d     = S_DRAIN;
          end else begin
            err_chk_d = 1'b1;
            state_d   = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        // Bytes arriving while the buffer is busy are dropped, even a SYNC
        // landing on the final handshake cycle.
        if (byte_ev) begin
          err_ovf_d = 1'b1;
        end
        if (bus.out_ready) begin
          rd_idx_d = rd_idx_q + 8'd1;
          if (drain_last) begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control and status registers; reset abandons any partial frame silently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rx_valid_q    <= 1'b0;
      len_q         <= '0;
      chk_q         <= '0;
      wr_idx_q      <= '0;
      rd_idx_q      <= '0;
      tmo_q         <= '0;
      pkt_count_q   <= '0;
      err_chk_q     <= 1'b0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rx_valid_q    <= bus.rx_valid;
      len_q         <= len_d;
      chk_q         <= chk_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      tmo_q         <= tmo_d;
      pkt_count_q   <= pkt_count_d;
      err_chk_q     <= err_chk_d;
      err_len_q     <= err_len_d;
      err_timeout_q <= err_timeout_d;
      err_ovf_q     <= err_ovf_d;
    end
  end

  // Payload buffer; contents are meaningless outside a verified frame
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_idx_q[IW-1:0]] <= bus.rx_data;
    end
  end

  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.out_last  = (state_q == S_DRAIN) && drain_last;
  assign bus.out_data  = (state_q == S_DRAIN) ? mem_q[rd_idx_q[IW-1:0]] : 8'd0;

  assign pkt_count   = pkt_count_q;
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_timeout_q;
  assign err_ovf     = err_ovf_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Bench for uart_rx_pkt_ctrl: frames are built from random payloads, the
// expected stream and error counts come from the frame's construction.
`timescale 1ns/1ps
module tb_uart_rx_pkt_ctrl;
  localparam int MAXL = 16;
  localparam int TMO  = 200;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] pkt_count;
  logic        err_chk, err_len, err_timeout, err_ovf;
  logic [2:0]  state_dbg;

  uart_rx_pkt_ctrl_if bus ();

  uart_rx_pkt_ctrl #(
    .SYNC_BYTE(8'hA5),
    .MAX_LEN  (MAXL),
    .TIMEOUT  (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.master),
    .pkt_count  (pkt_count),
    .err_chk    (err_chk),
    .err_len    (err_len),
    .err_timeout(err_timeout),
    .err_ovf    (err_ovf),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];   // {last, data}
  logic [8:0] got_q[$];
  int         hs_cyc[$];
  int cyc = 0;
  int ec = 0, el = 0, et = 0, eo = 0, vcyc = 0, idle_nz = 0;
  int exp_chk = 0, exp_len = 0, exp_tmo = 0, exp_ovf = 0, exp_pkt = 0;
  logic [7:0] pay [256];

  always @(posedge clk) cyc <= cyc + 1;

  // Observe the DUT away from the active edge
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      got_q.push_back({bus.out_last, bus.out_data});
      hs_cyc.push_back(cyc);
    end
    if (!bus.out_valid && (bus.out_data !== 8'd0 || bus.out_last !== 1'b0)) idle_nz = idle_nz + 1;
    if (bus.out_valid) vcyc = vcyc + 1;
    if (err_chk === 1'b1) ec = ec + 1;
    if (err_len === 1'b1) el = el + 1;
    if (err_timeout === 1'b1) et = et + 1;
    if (err_ovf === 1'b1) eo = eo + 1;
  end

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  task automatic fill_rand(input int len);
    for (int i = 0; i < len; i++) pay[i] = 8'($urandom_range(0, 255));
  endtask

  // Sends SYNC, LEN, pay[0..len-1], CHK (xor'ed with chk_xor to corrupt)
  task automatic send_pkt(input int len, input logic [7:0] chk_xor, input int hold);
    logic [7:0] s;
    s = 8'(len);
    send_byte(8'hA5, hold);
    send_byte(8'(len), hold);
    for (int i = 0; i < len; i++) begin
      send_byte(pay[i], hold);
      s = s + pay[i];
    end
    send_byte(s ^ chk_xor, hold);
    if (chk_xor == 8'd0) begin
      exp_pkt++;
      for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), pay[i]});
    end else begin
      exp_chk++;
    end
  endtask

  task automatic wait_drain(input int budget, input bit rand_rdy, output bit ok);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < budget) begin
      @(posedge clk); #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    ok = (got_q.size() >= exp_q.size());
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.out_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.out_valid === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.rx_data = 8'd0;
    bus.rx_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.out_last, bus.out_data} !== 10'd0) begin
      n_errors++; $display("FAIL reset_out: got v=%b l=%b d=%h, want 0", bus.out_valid, bus.out_last, bus.out_data);
    end
    n_checks++;
    if (pkt_count !== 16'd0) begin
      n_errors++; $display("FAIL reset_pkt_count: got %0d, want 0", pkt_count);
    end
    n_checks++;
    if ({err_chk, err_len, err_timeout, err_ovf} !== 4'd0 || state_dbg !== 3'd0) begin
      n_errors++; $display("FAIL reset_err_state: got err=%b state=%0d, want 0", {err_chk, err_len, err_timeout, err_ovf}, state_dbg);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_good_packet();
    bit ok;
    bus.out_ready = 1'b1;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    hs_cyc.delete();
    send_pkt(3, 8'h00, 1);
    wait_drain(200, 1'b0, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL good_count: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL good_byte: got %h, want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_checks++;
    if (hs_cyc.size() != 3 || hs_cyc[1] != hs_cyc[0] + 1 || hs_cyc[2] != hs_cyc[1] + 1) begin
      n_errors++; $display("FAIL good_back_to_back: got %0d handshakes not on consecutive cycles, want 3 consecutive", hs_cyc.size());
    end
    n_checks++;
    if (pkt_count !== 16'(exp_pkt) || ec != exp_chk || el != exp_len || et != exp_tmo || eo != exp_ovf) begin
      n_errors++; $display("FAIL good_status: got pkt=%0d chk=%0d len=%0d tmo=%0d ovf=%0d, want pkt=%0d errs=0", pkt_count, ec, el, et, eo, exp_pkt);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bus.out_ready = 1'b0;
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
    send_pkt(3, 8'h00, 1);
    wait_valid(50, ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL bp_valid_rise: got out_valid=%b, want 1", bus.out_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h11 || bus.out_last !== 1'b0) begin
        n_errors++; $display("FAIL bp_hold: got v=%b d=%h l=%b, want v=1 d=11 l=0", bus.out_valid, bus.out_data, bus.out_last);
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain(200, 1'b0, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL bp_count: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL bp_byte: got %h, want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_checks++;
    if (pkt_count !== 16'(exp_pkt)) begin n_errors++; $display("FAIL bp_pkt_count: got %0d, want %0d", pkt_count, exp_pkt); end
  endtask

  task automatic test_bad_chk();
    bit ok;
    int v0;
    bus.out_ready = 1'b1;
    v0 = vcyc;
    send_byte(8'hA5, 1); send_byte(8'h02, 1); send_byte(8'h10, 1); send_byte(8'h20, 1); send_byte(8'h00, 1);
    exp_chk++;
    repeat (4) @(posedge clk);
    n_checks++;
    if (ec != exp_chk || vcyc != v0 || pkt_count !== 16'(exp_pkt)) begin
      n_errors++; $display("FAIL bad_chk: got chk_pulses=%0d valid_cycles=%0d pkt=%0d, want %0d 0 %0d", ec, vcyc - v0, pkt_count, exp_chk, exp_pkt);
    end
    fill_rand(5);
    send_pkt(5, 8'h00, 1);
    wait_drain(200, 1'b0, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL after_bad_count: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL after_bad_byte: got %h, want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_len_err();
    bit ok;
    bus.out_ready = 1'b1;
    send_byte(8'h00, 1); send_byte(8'hFF, 1);
    send_byte(8'hA5, 1); send_byte(8'h00, 1); exp_len++;
    send_byte(8'hA5, 1); send_byte(8'(MAXL + 1), 1); exp_len++;
    repeat (3) @(posedge clk);
    n_checks++;
    if (el != exp_len || ec != exp_chk || et != exp_tmo) begin
      n_errors++; $display("FAIL len_err: got len=%0d chk=%0d tmo=%0d, want %0d %0d %0d", el, ec, et, exp_len, exp_chk, exp_tmo);
    end
    fill_rand(MAXL);
    send_pkt(MAXL, 8'h00, 1);
    wait_drain(300, 1'b0, ok);
    fill_rand(1);
    send_pkt(1, 8'h00, 1);
    wait_drain(300, 1'b0, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL len_bound_count: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL len_bound_byte: got %h, want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_timeout();
    bit ok;
    int t0;
    bus.out_ready = 1'b1;
    send_byte(8'hA5, 1); send_byte(8'h04, 1); send_byte(8'h01, 1);
    t0 = cyc;
    while (et == exp_tmo && cyc - t0 < TMO + 50) @(posedge clk);
    exp_tmo++;
    n_checks++;
    if (et != exp_tmo || cyc - t0 < TMO - 10) begin
      n_errors++; $display("FAIL timeout_pulse: got pulses=%0d after %0d cycles, want %0d near %0d", et, cyc - t0, exp_tmo, TMO);
    end
    fill_rand(4);
    send_pkt(4, 8'h00, 1);
    wait_drain(200, 1'b0, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size() || et != exp_tmo) begin
      n_errors++; $display("FAIL after_tmo_count: got %0d bytes tmo=%0d, want %0d tmo=%0d", got_q.size(), et, exp_q.size(), exp_tmo);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL after_tmo_byte: got %h, want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_level_held();
    bit ok;
    bus.out_ready = 1'b1;
    fill_rand(2);
    send_pkt(2, 8'h00, 20);
    wait_drain(200, 1'b0, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size() || el != exp_len || pkt_count !== 16'(exp_pkt)) begin
      n_errors++; $display("FAIL level_held: got %0d bytes len_err=%0d pkt=%0d, want %0d %0d %0d", got_q.size(), el, pkt_count, exp_q.size(), exp_len, exp_pkt);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL level_byte: got %h, want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    bit ok;
    bus.out_ready = 1'b0;
    fill_rand(3);
    send_pkt(3, 8'h00, 1);
    wait_valid(50, ok);
    send_byte(8'hA5, 1);
    exp_ovf++;
    @(negedge clk);
    n_checks++;
    if (eo != exp_ovf || bus.out_valid !== 1'b1 || bus.out_data !== pay[0]) begin
      n_errors++; $display("FAIL ovf_pulse: got ovf=%0d v=%b d=%h, want %0d 1 %h", eo, bus.out_valid, bus.out_data, exp_ovf, pay[0]);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_drain(200, 1'b0, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL ovf_count: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL ovf_byte: got %h, want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    // A dropped SYNC must not have opened a frame: a zero now is just noise
    send_byte(8'h00, 1);
    repeat (3) @(posedge clk);
    n_checks++;
    if (el != exp_len || eo != exp_ovf) begin
      n_errors++; $display("FAIL ovf_sync_dropped: got len=%0d ovf=%0d, want %0d %0d", el, eo, exp_len, exp_ovf);
    end
  endtask

  task automatic test_random();
    bit ok;
    int len;
    logic [7:0] xr;
    for (int p = 0; p < 15; p++) begin
      len = $urandom_range(1, MAXL);
      fill_rand(len);
      xr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      bus.out_ready = 1'b1;
      send_pkt(len, xr, $urandom_range(1, 3));
      wait_drain(2000, 1'b1, ok);
    end
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL rand_count: got %0d bytes, want %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL rand_byte: got %h, want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
    n_checks++;
    if (pkt_count !== 16'(exp_pkt) || ec != exp_chk || eo != exp_ovf || et != exp_tmo) begin
      n_errors++; $display("FAIL rand_status: got pkt=%0d chk=%0d ovf=%0d tmo=%0d, want %0d %0d %0d %0d", pkt_count, ec, eo, et, exp_pkt, exp_chk, exp_ovf, exp_tmo);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bus.out_ready = 1'b1;
    send_byte(8'hA5, 1); send_byte(8'h05, 1); send_byte(8'h01, 1); send_byte(8'h02, 1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_last, bus.out_data} !== 10'd0 || pkt_count !== 16'd0 || state_dbg !== 3'd0 ||
        {err_chk, err_len, err_timeout, err_ovf} !== 4'd0) begin
      n_errors++; $display("FAIL reset_mid: got v=%b d=%h pkt=%0d state=%0d, want all 0", bus.out_valid, bus.out_data, pkt_count, state_dbg);
    end
    exp_pkt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    fill_rand(3);
    send_pkt(3, 8'h00, 1);
    wait_drain(200, 1'b0, ok);
    n_checks++;
    if (!ok || got_q.size() != exp_q.size() || pkt_count !== 16'(exp_pkt) ||
        ec != exp_chk || el != exp_len || et != exp_tmo || eo != exp_ovf) begin
      n_errors++; $display("FAIL reset_resume: got %0d bytes pkt=%0d, want %0d pkt=%0d with no new errors", got_q.size(), pkt_count, exp_q.size(), exp_pkt);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      logic [8:0] e, g;
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_checks++;
      if (g !== e) begin n_errors++; $display("FAIL reset_resume_byte: got %h, want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_idle_zero();
    n_checks++;
    if (idle_nz != 0) begin
      n_errors++; $display("FAIL idle_out_zero: got %0d cycles with nonzero data/last while idle, want 0", idle_nz);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_good_packet();
    test_backpressure();
    test_bad_chk();
    test_len_err();
    test_timeout();
    test_level_held();
    test_overflow();
    test_random();
    test_reset_mid();
    test_idle_zero();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
